reset_register_ctrl: RTL

- Writer side of the peripheral reset register: the host writes a 6-bit reset request, and this block drives ResetRegister[5:0] into the reset decode logic (bit4 = Reset1G, bit3 = ResetDB, bit5 = Reset10G).
- Each bit is sequenced by its own timer FSM. This guarantees a minimum assert pulse and a recovery gap, with optional auto-release.
- Sits between the host register bus and the reset decode stage, inside MR_Bsp.

---
 rtl/rst_ctrl_pkg.sv | 15 +
 rtl/reset_bit_seq.sv | 86 ++++++++
 rtl/reset_register_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/rst_ctrl_pkg.sv
// rst_ctrl_pkg: shared state encoding and reset-bit index constants for reset_register_ctrl.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HELD    = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam int RST_BIT_DB  = 3;
    localparam int RST_BIT_1G  = 4;
    localparam int RST_BIT_10G = 5;

endpackage

// File: rtl/reset_bit_seq.sv
// reset_bit_seq: one reset bit's timer FSM (min assert pulse, recovery gap, optional auto-release).
module reset_bit_seq
    import rst_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES   = 3300,
    parameter int RECOVER_CYCLES = 330,
    parameter int CNT_W          = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic wr_i,
    input  logic data_i,
    input  logic auto_i,
    output logic out_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LD = CNT_W'(RECOVER_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             pend_q, pend_d, pend_w;
    logic             out_q, busy_q;

    // a write landing on the RECOVER expiry cycle still counts as the pending request
    assign pend_w = wr_i ? data_i : pend_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pend_d  = pend_q;
        if (clr_i) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (wr_i && data_i) begin
                    state_d = ST_ASSERT;
                    tmr_d   = P_LD;
                end
                ST_ASSERT: if (tmr_q == '0) begin
                    state_d = auto_i ? ST_RECOVER : ST_HELD;
                    tmr_d   = auto_i ? R_LD : '0;
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
                ST_HELD: if (wr_i && !data_i) begin
                    state_d = ST_RECOVER;
                    tmr_d   = R_LD;
                end
                ST_RECOVER: if (tmr_q == '0) begin
                    state_d = pend_w ? ST_ASSERT : ST_IDLE;
                    tmr_d   = pend_w ? P_LD : '0;
                    pend_d  = 1'b0;
                end else begin
                    tmr_d  = tmr_q - CNT_W'(1);
                    pend_d = pend_w;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            out_q   <= (state_d == ST_ASSERT) || (state_d == ST_HELD);
            busy_q  <= (state_d == ST_ASSERT) || (state_d == ST_RECOVER);
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/reset_register_ctrl.sv
// reset_register_ctrl: sequenced peripheral reset register writer; RESET_LOCK_EN adds a sticky write lock.
module reset_register_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int NUM_BITS       = 6,
    parameter int PULSE_CYCLES   = 3300,
    parameter int RECOVER_CYCLES = 330,
    parameter int CNT_W          = 16
) (
    input  logic                  Clk33M,
    input  logic                  MainReset,
    input  logic                  PciReset,
    input  logic                  WrEn,
    input  logic [NUM_BITS-1:0]   WrData,
    input  logic [NUM_BITS-1:0]   AutoClrMask,
    output logic [NUM_BITS-1:0]   ResetRegister,
    output logic [NUM_BITS-1:0]   Busy,
`ifdef RESET_LOCK_EN
    input  logic                  Lock,
    output logic [2*NUM_BITS:0]   RdData
`else
    output logic [2*NUM_BITS-1:0] RdData
`endif
);

    logic wr_en;

`ifdef RESET_LOCK_EN
    logic lock_q, lock_d;

    // the lock takes hold in the same cycle Lock is raised
    assign lock_d = lock_q | Lock;
    assign wr_en  = WrEn & ~lock_d;

    always_ff @(posedge Clk33M) begin
        if (!MainReset) lock_q <= 1'b0;
        else            lock_q <= lock_d;
    end

    assign RdData = {lock_q, Busy, ResetRegister};
`else
    assign wr_en  = WrEn;
    assign RdData = {Busy, ResetRegister};
`endif

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
        reset_bit_seq #(
            .PULSE_CYCLES  (PULSE_CYCLES),
            .RECOVER_CYCLES(RECOVER_CYCLES),
            .CNT_W         (CNT_W)
        ) u_seq (
            .clk_i  (Clk33M),
            .rst_n_i(MainReset),
            .clr_i  ((i == RST_BIT_DB) ? ~PciReset : 1'b0),
            .wr_i   (wr_en),
            .data_i (WrData[i]),
            .auto_i (AutoClrMask[i]),
            .out_o  (ResetRegister[i]),
            .busy_o (Busy[i])
        );
    end

endmodule
